apb_timer: RTL and testbench
============================

Name: apb_timer

Overview:
- APB slave countdown timer on the peripheral bus, driven directly by the AHB-to-APB bridge stage.
- Provides:
  - a software-programmable reload value
  - an 8-bit prescaler
  - periodic or one-shot modes
  - a level interrupt with write-1-to-clear status
- Zero-wait-state APB access. All state is in the single bus clock domain.

Parameters:
- WIDTH, 32, counter and LOAD/VALUE register width (8..32); APB data bus stays 32 bits, unused upper bits read 0.
- RESET_LOAD, 0, reset value of LOAD and VALUE.

Ports:
- PCLK  input  1  bus clock, rising-edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1=write, 0=read.
- PADDR  input  32  byte address; only [3:2] decoded.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  error response.
- TIMER_IRQ  output  1  level interrupt.

Behaviour:
- Reset (PRESET=1, any time, asynchronous):
  - LOAD=VALUE=RESET_LOAD; CTRL=0; INTSTAT=0; prescale counter=0.
  - PRDATA=0, PREADY=1, PSLVERR=0, TIMER_IRQ=0.
  - Reset mid-count or mid-transfer abandons the operation; no partial register write.
- Bus protocol:
  - Setup phase is PSEL=1, PENABLE=0; access phase is PSEL=1, PENABLE=1.
  - PREADY=1 constant, so every access completes in its access phase.
  - Register writes take effect at the PCLK edge ending the access phase (wr_en = PSEL&PENABLE&PWRITE).
  - PRDATA is registered: loaded at the edge ending the setup phase (PSEL&!PENABLE&!PWRITE) and held until the next read.
  - Back-to-back transfers are supported.
- Register map (PADDR[3:2]):
  - 0 LOAD, RW.
  - 1 VALUE, RO; writes ignored.
  - 2 CTRL, RW: [0] EN, [1] ONESHOT, [2] IRQEN, [15:8] PRESCALE; other bits read 0.
  - 3 INTSTAT, [0] INT; write 1 clears, write 0 no effect.
- Prescaler and tick:
  - While EN=1, the prescale counter increments each cycle.
  - When the counter equals PRESCALE, a tick occurs and the counter returns to 0 on the same edge. PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - While EN=0, the counter holds at 0.
- On tick:
  - If VALUE!=0: VALUE decrements by 1.
  - If VALUE==0: INT is set.
    - Periodic mode: VALUE reloads from LOAD.
    - One-shot mode: VALUE stays 0 and EN clears to 0.
  - Period is therefore (LOAD+1)*(PRESCALE+1) cycles.
  - With LOAD=0 in periodic mode, INT is set every tick.
- LOAD write: VALUE and LOAD both take PWDATA[WIDTH-1:0] on the same edge, and the prescale counter clears. This write has priority over a tick in that cycle.
- CTRL write: a 0->1 transition of EN clears the prescale counter.
- Simultaneous INTSTAT write-1-clear and INT set: set wins; INT stays 1.
- TIMER_IRQ = INT & IRQEN, registered-free combinational AND of two flops. INT sets regardless of IRQEN.
- Wrap-around: VALUE never underflows below 0; the decrement occurs only when VALUE!=0.

Optional Feature:
- Macro: APB_TIMER_PSLVERR_EN.
- Defined:
  - PSLVERR=1 during the access phase of any write to VALUE (offset 0x4), or of any access with PADDR[31:4]!=0 relative to the block's 4-word window (PADDR[11:4]!=0).
  - The erroring write has no effect.
  - An erroring read returns 0.
  - PSLVERR=0 in all other cycles.
- Undefined: PSLVERR tied 0; only PADDR[3:2] decoded (aliasing); writes to VALUE silently ignored.

Test Plan:
- Reset: assert PRESET for 3 cycles mid-count → all registers read 0, TIMER_IRQ=0, PREADY=1.
- Periodic: LOAD=3, CTRL=0x0005 (EN, IRQEN, PRESCALE=0) → VALUE reads 3,2,1,0; INT/TIMER_IRQ rise on the 4th tick after the CTRL write; VALUE reloads 3; period 4 cycles thereafter.
- Prescale one-shot: LOAD=2, CTRL=0x0303 (EN, ONESHOT, PRESCALE=3) → INT set 12 cycles after enable; EN reads 0; VALUE stays 0; no further change over 50 cycles.
- Clear race: force a write of 1 to INTSTAT on the same edge as an INT-setting tick (LOAD=0, periodic) → INT reads 1. The next clear without a coincident tick leaves INT=0, and TIMER_IRQ drops the following cycle.
- Bus: back-to-back write LOAD=0xA5 then read LOAD → PRDATA=0x000000A5, PREADY=1 in every access phase. Write to VALUE → VALUE unchanged.
- With APB_TIMER_PSLVERR_EN: write 0x1 to offset 0x4 → PSLVERR=1 in the access phase, VALUE unchanged. Read offset 0x10 → PSLVERR=1, PRDATA=0.

Source files
------------

// File: rtl/apb_timer.sv
// APB countdown timer: reload value, 8-bit prescaler, periodic/one-shot modes, level IRQ with W1C status.
// Latency: zero-wait-state; writes land at the access-phase edge, PRDATA registered at the setup-phase edge.
// Backpressure: none, PREADY is constantly 1. Optional APB_TIMER_PSLVERR_EN adds error responses.
`timescale 1ns/1ps

module apb_timer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_LOAD = '0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        TIMER_IRQ
);

    localparam logic [1:0] ADDR_LOAD    = 2'd0;
    localparam logic [1:0] ADDR_VALUE   = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_INTSTAT = 2'd3;

    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] value_q;
    logic             ctrl_en;
    logic             ctrl_oneshot;
    logic             ctrl_irqen;
    logic [7:0]       ctrl_prescale;
    logic             int_q;
    logic [7:0]       pre_cnt;

    logic [1:0]       reg_sel;
    logic             rd_err;
    logic             wr_err;
    logic             acc_err;
    logic             wr_en;
    logic             rd_en;
    logic             wr_load;
    logic             wr_ctrl;
    logic             wr_int;
    logic             en_rise;
    logic             tick;
    logic             tick_eff;
    logic             expire;
    logic [31:0]      rd_mux;

    assign reg_sel = PADDR[3:2];

`ifdef APB_TIMER_PSLVERR_EN
    // Anything outside the 4-word window errors; VALUE is read-only so writing it errors too.
    assign rd_err  = (PADDR[11:4] != 8'd0);
    assign wr_err  = rd_err || (reg_sel == ADDR_VALUE);
    assign acc_err = PWRITE ? wr_err : rd_err;
    assign PSLVERR = PSEL && PENABLE && acc_err;

    logic unused_bits;
    assign unused_bits = ^{PADDR[31:12], PADDR[1:0], PWDATA};
`else
    // Only PADDR[3:2] decoded: the register window aliases across the address space.
    assign rd_err  = 1'b0;
    assign wr_err  = 1'b0;
    assign acc_err = 1'b0;
    assign PSLVERR = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA, wr_err};
`endif

    assign PREADY  = 1'b1;
    assign wr_en   = PSEL && PENABLE && PWRITE && !acc_err;
    assign rd_en   = PSEL && !PENABLE && !PWRITE;
    assign wr_load = wr_en && (reg_sel == ADDR_LOAD);
    assign wr_ctrl = wr_en && (reg_sel == ADDR_CTRL);
    assign wr_int  = wr_en && (reg_sel == ADDR_INTSTAT);
    assign en_rise = wr_ctrl && PWDATA[0] && !ctrl_en;

    // A LOAD write pre-empts any tick landing on the same edge.
    assign tick     = ctrl_en && (pre_cnt == ctrl_prescale);
    assign tick_eff = tick && !wr_load;
    assign expire   = tick_eff && (value_q == '0);

    assign TIMER_IRQ = int_q && ctrl_irqen;

    // Prescale counter: free-runs while enabled, restarts on reload, enable edge or tick.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pre_cnt <= 8'd0;
        end else if (wr_load || en_rise || (wr_ctrl && !PWDATA[0])) begin
            pre_cnt <= 8'd0;
        end else if (!ctrl_en || tick) begin
            pre_cnt <= 8'd0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    // LOAD register and the down-counting VALUE.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            load_q  <= RESET_LOAD;
            value_q <= RESET_LOAD;
        end else if (wr_load) begin
            load_q  <= PWDATA[WIDTH-1:0];
            value_q <= PWDATA[WIDTH-1:0];
        end else if (tick_eff) begin
            if (value_q != '0) begin
                value_q <= value_q - WIDTH'(1);
            end else if (!ctrl_oneshot) begin
                value_q <= load_q;
            end
        end
    end

    // CTRL fields; one-shot expiry drops EN unless software writes CTRL on that edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_en       <= 1'b0;
            ctrl_oneshot  <= 1'b0;
            ctrl_irqen    <= 1'b0;
            ctrl_prescale <= 8'd0;
        end else if (wr_ctrl) begin
            ctrl_en       <= PWDATA[0];
            ctrl_oneshot  <= PWDATA[1];
            ctrl_irqen    <= PWDATA[2];
            ctrl_prescale <= PWDATA[15:8];
        end else if (expire && ctrl_oneshot) begin
            ctrl_en       <= 1'b0;
        end
    end

    // Interrupt status: a set on the same edge as a write-1-clear wins.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            int_q <= 1'b0;
        end else if (expire) begin
            int_q <= 1'b1;
        end else if (wr_int && PWDATA[0]) begin
            int_q <= 1'b0;
        end
    end

    // Read mux, zero-filling unused bits.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            ADDR_LOAD:    rd_mux[WIDTH-1:0] = load_q;
            ADDR_VALUE:   rd_mux[WIDTH-1:0] = value_q;
            ADDR_CTRL: begin
                rd_mux[0]    = ctrl_en;
                rd_mux[1]    = ctrl_oneshot;
                rd_mux[2]    = ctrl_irqen;
                rd_mux[15:8] = ctrl_prescale;
            end
            ADDR_INTSTAT: rd_mux[0] = int_q;
            default:      rd_mux = '0;
        endcase
    end

    // Read data captured at the end of the setup phase and held until the next read.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PRDATA <= 32'd0;
        end else if (rd_en) begin
            PRDATA <= rd_err ? 32'd0 : rd_mux;
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: reset, periodic, prescaled one-shot, W1C race, bus access.
// Latency: drives on falling edges, samples on falling edges.
// Backpressure: none expected; PREADY checked in every access phase.
`timescale 1ns/1ps

module tb_apb_timer;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        TIMER_IRQ;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd_dat;

`ifdef APB_TIMER_PSLVERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    int exp_val [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    int exp_irq [8] = '{0, 0, 0, 1, 1, 1, 1, 1};

    always #5 PCLK = ~PCLK;

    apb_timer dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .TIMER_IRQ (TIMER_IRQ)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the access phase.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = addr;
        PWDATA  = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        check("wr_pready", {31'd0, PREADY}, 32'd1);
        check("wr_pslverr", {31'd0, PSLVERR}, {31'd0, exp_err});
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, input logic exp_err);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        check("rd_pready", {31'd0, PREADY}, 32'd1);
        check("rd_pslverr", {31'd0, PSLVERR}, {31'd0, exp_err});
        data = PRDATA;
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'd0;
        PWDATA  = 32'd0;
        repeat (2) @(negedge PCLK);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd1);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_irq", {31'd0, TIMER_IRQ}, 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Periodic, LOAD=3, PRESCALE=0: one tick per cycle, period 4.
        apb_write(32'h0, 32'd3, 1'b0);
        apb_write(32'h8, 32'h0000_0005, 1'b0);
        check("per_v0", dut.value_q, 32'd3);
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            check($sformatf("per_val%0d", i), dut.value_q, exp_val[i]);
            check($sformatf("per_irq%0d", i), {31'd0, TIMER_IRQ}, exp_irq[i]);
        end
        apb_read(32'h0, rd_dat, 1'b0);
        check("per_load", rd_dat, 32'd3);

        // Reset mid-count, held 3 cycles.
        PRESET = 1'b1;
        #1;
        check("mid_rst_prdata", PRDATA, 32'd0);
        check("mid_rst_irq", {31'd0, TIMER_IRQ}, 32'd0);
        check("mid_rst_pready", {31'd0, PREADY}, 32'd1);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        for (int a = 0; a < 4; a++) begin
            apb_read(32'(a * 4), rd_dat, 1'b0);
            check($sformatf("mid_rst_reg%0d", a), rd_dat, 32'd0);
        end

        // W1C racing a set: LOAD=0 periodic sets INT every cycle.
        apb_write(32'h0, 32'd0, 1'b0);
        apb_write(32'h8, 32'h0000_0005, 1'b0);
        apb_write(32'hC, 32'd1, 1'b0);
        apb_read(32'hC, rd_dat, 1'b0);
        check("race_int", rd_dat, 32'd1);
        apb_write(32'h8, 32'h0000_0004, 1'b0);
        check("race_irq_before", {31'd0, TIMER_IRQ}, 32'd1);
        apb_write(32'hC, 32'd1, 1'b0);
        check("clr_irq_after", {31'd0, TIMER_IRQ}, 32'd0);
        apb_read(32'hC, rd_dat, 1'b0);
        check("clr_int", rd_dat, 32'd0);

        // One-shot, LOAD=2, PRESCALE=3: expires 12 cycles after enable.
        apb_write(32'h0, 32'd2, 1'b0);
        apb_write(32'h8, 32'h0000_0303, 1'b0);
        repeat (11) @(negedge PCLK);
        check("os_int_c11", {31'd0, dut.int_q}, 32'd0);
        check("os_val_c11", dut.value_q, 32'd0);
        @(negedge PCLK);
        check("os_int_c12", {31'd0, dut.int_q}, 32'd1);
        check("os_en_c12", {31'd0, dut.ctrl_en}, 32'd0);
        apb_read(32'h8, rd_dat, 1'b0);
        check("os_ctrl", rd_dat, 32'h0000_0302);
        apb_read(32'h4, rd_dat, 1'b0);
        check("os_val", rd_dat, 32'd0);
        repeat (50) @(negedge PCLK);
        apb_read(32'h4, rd_dat, 1'b0);
        check("os_val_late", rd_dat, 32'd0);
        apb_read(32'hC, rd_dat, 1'b0);
        check("os_int_late", rd_dat, 32'd1);
        apb_read(32'h8, rd_dat, 1'b0);
        check("os_ctrl_late", rd_dat, 32'h0000_0302);
        check("os_irq_masked", {31'd0, TIMER_IRQ}, 32'd0);

        // Back-to-back write/read, and VALUE write protection.
        apb_write(32'h0, 32'h0000_00A5, 1'b0);
        apb_read(32'h0, rd_dat, 1'b0);
        check("bus_load", rd_dat, 32'h0000_00A5);
        apb_read(32'h4, rd_dat, 1'b0);
        check("bus_val", rd_dat, 32'h0000_00A5);
        apb_write(32'h4, 32'h0000_0001, ERR_EXP);
        apb_read(32'h4, rd_dat, 1'b0);
        check("bus_val_ro", rd_dat, 32'h0000_00A5);
`ifdef APB_TIMER_PSLVERR_EN
        apb_read(32'h10, rd_dat, 1'b1);
        check("bus_oob_rd", rd_dat, 32'd0);
`else
        apb_read(32'h10, rd_dat, 1'b0);
        check("bus_alias_rd", rd_dat, 32'h0000_00A5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
